// File: rtl/iterative_divider_v2_if.sv
// ============================================================================
// Module      : iterative_divider_v2_if
// Description : Request/response bundle for iterative_divider_v2. The
//               requester side uses the master modport; the divider uses slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface iterative_divider_v2_if #(
  parameter int P_WIDTH     = 32,
  parameter int P_TAG_WIDTH = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_signed;
  logic [P_WIDTH-1:0]     in_dividend;
  logic [P_WIDTH-1:0]     in_divisor;
  logic [P_TAG_WIDTH-1:0] in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [P_WIDTH-1:0]     out_quotient;
  logic [P_WIDTH-1:0]     out_remainder;
  logic                   out_div_by_zero;
  logic                   out_overflow;
  logic [P_TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, in_signed, in_dividend, in_divisor, in_tag, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder,
           out_div_by_zero, out_overflow, out_tag
  );

  modport slave (
    input  in_valid, in_signed, in_dividend, in_divisor, in_tag, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder,
           out_div_by_zero, out_overflow, out_tag
  );
endinterface

`default_nettype wire

// File: rtl/iterative_divider_v2.sv
// ============================================================================
// Module      : iterative_divider_v2
// Description : Iterative restoring integer divider, signed or unsigned,
//               P_BITS_PER_CYCLE quotient bits per cycle, with divide-by-zero
//               and signed-overflow bypass paths and a pass-through tag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iterative_divider_v2 #(
  parameter int P_WIDTH          = 32,
  parameter int P_BITS_PER_CYCLE = 1,
  parameter int P_TAG_WIDTH      = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  iterative_divider_v2_if.slave  bus
);

  localparam int c_iters = P_WIDTH / P_BITS_PER_CYCLE;
  localparam int c_cnt_w = $clog2(c_iters + 1);
  localparam logic [P_WIDTH-1:0] c_min = {1'b1, {(P_WIDTH-1){1'b0}}};

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_calc  = 2'd1;
  localparam logic [1:0] c_fixup = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  logic [1:0]             r_state;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [P_WIDTH:0]       r_acc;    // partial remainder
  logic [P_WIDTH-1:0]     r_quo;    // dividend bits shift out, quotient bits shift in
  logic [P_WIDTH-1:0]     r_dvsr;   // divisor magnitude
  logic                   r_qneg;
  logic                   r_rneg;
  logic [P_TAG_WIDTH-1:0] r_tag;
  logic [P_WIDTH-1:0]     r_out_q;
  logic [P_WIDTH-1:0]     r_out_r;
  logic                   r_out_dbz;
  logic                   r_out_ovf;
  logic [P_TAG_WIDTH-1:0] r_out_tag;

  logic                   w_dvd_neg;
  logic                   w_dvs_neg;
  logic [P_WIDTH-1:0]     w_dvd_mag;
  logic [P_WIDTH-1:0]     w_dvs_mag;
  logic                   w_is_zero;
  logic                   w_is_ovf;
  logic [P_WIDTH:0]       w_acc;
  logic [P_WIDTH-1:0]     w_quo;
  logic [P_WIDTH-1:0]     w_fix;

  // Operand signs and magnitudes are only meaningful at the accepting edge.
  assign w_dvd_neg = bus.in_signed & bus.in_dividend[P_WIDTH-1];
  assign w_dvs_neg = bus.in_signed & bus.in_divisor[P_WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? (-bus.in_dividend) : bus.in_dividend;
  assign w_dvs_mag = w_dvs_neg ? (-bus.in_divisor) : bus.in_divisor;
  assign w_is_zero = (bus.in_divisor == '0);
  assign w_is_ovf  = bus.in_signed && (bus.in_dividend == c_min) && (bus.in_divisor == '1);

  // Restoring steps never leave the accumulator negative, so this add is a no-op
  // in practice; it keeps the fixup correct should the step scheme change.
  assign w_fix = r_acc[P_WIDTH-1:0] + (r_acc[P_WIDTH] ? r_dvsr : '0);

  assign bus.in_ready        = (r_state == c_idle);
  assign bus.out_valid       = (r_state == c_done);
  assign bus.out_quotient    = r_out_q;
  assign bus.out_remainder   = r_out_r;
  assign bus.out_div_by_zero = r_out_dbz;
  assign bus.out_overflow    = r_out_ovf;
  assign bus.out_tag         = r_out_tag;

  // Unrolled restoring division: P_BITS_PER_CYCLE shift/compare/subtract steps, MSB first.
  always_comb begin
    w_acc = r_acc;
    w_quo = r_quo;
    for (int k = 0; k < P_BITS_PER_CYCLE; k++) begin
      w_acc = {w_acc[P_WIDTH-1:0], w_quo[P_WIDTH-1]};
      w_quo = {w_quo[P_WIDTH-2:0], 1'b0};
      if (w_acc >= {1'b0, r_dvsr}) begin
        w_acc    = w_acc - {1'b0, r_dvsr};
        w_quo[0] = 1'b1;
      end
    end
  end

  // Control FSM and datapath registers; outputs update only when entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_idle;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_tag     <= '0;
      r_out_q   <= '0;
      r_out_r   <= '0;
      r_out_dbz <= 1'b0;
      r_out_ovf <= 1'b0;
      r_out_tag <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (bus.in_valid) begin
            if (w_is_zero) begin
              r_out_q   <= '1;
              r_out_r   <= bus.in_dividend;
              r_out_dbz <= 1'b1;
              r_out_ovf <= 1'b0;
              r_out_tag <= bus.in_tag;
              r_state   <= c_done;
            end else if (w_is_ovf) begin
              r_out_q   <= c_min;
              r_out_r   <= '0;
              r_out_dbz <= 1'b0;
              r_out_ovf <= 1'b1;
              r_out_tag <= bus.in_tag;
              r_state   <= c_done;
            end else begin
              r_acc   <= '0;
              r_quo   <= w_dvd_mag;
              r_dvsr  <= w_dvs_mag;
              r_qneg  <= w_dvd_neg ^ w_dvs_neg;
              r_rneg  <= w_dvd_neg;
              r_tag   <= bus.in_tag;
              r_cnt   <= c_cnt_w'(c_iters);
              r_state <= c_calc;
            end
          end
        end
        c_calc: begin
          r_acc <= w_acc;
          r_quo <= w_quo;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_cnt_w'(1)) begin
            r_state <= c_fixup;
          end
        end
        c_fixup: begin
          r_out_q   <= r_qneg ? (-r_quo) : r_quo;
          r_out_r   <= r_rneg ? (-w_fix) : w_fix;
          r_out_dbz <= 1'b0;
          r_out_ovf <= 1'b0;
          r_out_tag <= r_tag;
          r_state   <= c_done;
        end
        default: begin
          if (bus.out_ready) begin
            r_state <= c_idle;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iterative_divider_v2.sv
// ============================================================================
// Module      : tb_iterative_divider_v2
// Description : Self-checking bench for iterative_divider_v2; drives one DUT
//               at 1 bit/cycle and one at 4 bits/cycle against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iterative_divider_v2;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
    logic [3:0]  tag;
  } res_t;

  typedef struct packed {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  iterative_divider_v2_if #(.P_WIDTH(32), .P_TAG_WIDTH(4)) if1 ();
  iterative_divider_v2_if #(.P_WIDTH(32), .P_TAG_WIDTH(4)) if4 ();

  iterative_divider_v2 #(.P_WIDTH(32), .P_BITS_PER_CYCLE(1), .P_TAG_WIDTH(4)) u_div1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  iterative_divider_v2 #(.P_WIDTH(32), .P_BITS_PER_CYCLE(4), .P_TAG_WIDTH(4)) u_div4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- access
  task automatic drive_in(input int sel, input logic v, input logic s,
                          input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    if (sel == 1) begin
      if1.in_valid = v; if1.in_signed = s; if1.in_dividend = a; if1.in_divisor = b; if1.in_tag = t;
    end else begin
      if4.in_valid = v; if4.in_signed = s; if4.in_dividend = a; if4.in_divisor = b; if4.in_tag = t;
    end
  endtask

  task automatic drive_ordy(input int sel, input logic v);
    if (sel == 1) if1.out_ready = v;
    else          if4.out_ready = v;
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 1) ? if1.in_ready : if4.in_ready;
  endfunction

  function automatic logic vld(input int sel);
    return (sel == 1) ? if1.out_valid : if4.out_valid;
  endfunction

  function automatic res_t get_res(input int sel);
    res_t g;
    if (sel == 1) begin
      g.q = if1.out_quotient; g.r = if1.out_remainder; g.dz = if1.out_div_by_zero;
      g.ov = if1.out_overflow; g.tag = if1.out_tag;
    end else begin
      g.q = if4.out_quotient; g.r = if4.out_remainder; g.dz = if4.out_div_by_zero;
      g.ov = if4.out_overflow; g.tag = if4.out_tag;
    end
    return g;
  endfunction

  // ---------------------------------------------------------------- model
  function automatic res_t model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] t);
    res_t   m;
    longint sa;
    longint sb;
    m.tag = t; m.dz = 1'b0; m.ov = 1'b0;
    if (b == 32'd0) begin
      m.q = 32'hFFFF_FFFF; m.r = a; m.dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      m.q = 32'h8000_0000; m.r = 32'd0; m.ov = 1'b1;
    end else begin
      sa = s ? longint'($signed(a)) : longint'({32'd0, a});
      sb = s ? longint'($signed(b)) : longint'({32'd0, b});
      m.q = 32'(sa / sb);
      m.r = 32'(sa % sb);
    end
    return m;
  endfunction

  function automatic int exp_lat(input int sel, input res_t m);
    return (m.dz || m.ov) ? 1 : (32 / sel) + 2;
  endfunction

  function automatic vec_t mk(input logic s, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] q, input logic [31:0] r,
                              input logic dz, input logic ov);
    vec_t v;
    v.s = s; v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz; v.ov = ov;
    return v;
  endfunction

  // One full transaction; lat counts edges from the accepting edge (inclusive)
  // to the first one after which out_valid is seen, or -1 on timeout.
  task automatic run_req(input int sel, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] t,
                         output res_t res, output int lat);
    int n;
    @(negedge clk);
    drive_in(sel, 1'b1, s, a, b, t);
    n = 0;
    while (!rdy(sel) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    drive_in(sel, 1'b0, ~s, $urandom, $urandom, ~t);
    lat = 1;
    while (!vld(sel) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!vld(sel)) lat = -1;
    res = get_res(sel);
    drive_ordy(sel, 1'b1);
    @(negedge clk);
    drive_ordy(sel, 1'b0);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    res_t zero;
    zero = '0;
    rst_n = 1'b0;
    drive_in(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive_in(4, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive_ordy(1, 1'b0);
    drive_ordy(4, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int sel = 1; sel <= 4; sel += 3) begin
      checks++;
      if (vld(sel) !== 1'b0) begin
        errors++; $display("FAIL reset_valid sel=%0d: got %b, expected 0", sel, vld(sel));
      end
      checks++;
      if (rdy(sel) !== 1'b1) begin
        errors++; $display("FAIL reset_ready sel=%0d: got %b, expected 1", sel, rdy(sel));
      end
      checks++;
      if (get_res(sel) !== zero) begin
        errors++; $display("FAIL reset_outputs sel=%0d: got %h, expected 0", sel, get_res(sel));
      end
    end
  endtask

  task automatic test_directed(input int sel);
    vec_t v[10];
    res_t got;
    res_t exp;
    int   lat;
    int   elat;
    v[0] = mk(0, 32'd100,        32'd7,          32'd14,         32'd2,          0, 0);
    v[1] = mk(1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  0, 0);
    v[2] = mk(1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          0, 0);
    v[3] = mk(0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          0, 0);
    v[4] = mk(0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1, 0);
    v[5] = mk(1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1, 0);
    v[6] = mk(1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          0, 1);
    v[7] = mk(0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  0, 0);
    v[8] = mk(1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          0, 0);
    v[9] = mk(1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  0, 0);
    for (int i = 0; i < 10; i++) begin
      run_req(sel, v[i].s, v[i].a, v[i].b, 4'(i + 3), got, lat);
      exp.q = v[i].q; exp.r = v[i].r; exp.dz = v[i].dz; exp.ov = v[i].ov; exp.tag = 4'(i + 3);
      elat = (v[i].dz || v[i].ov) ? 1 : (32 / sel) + 2;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL directed_result sel=%0d case=%0d: got q=%h r=%h dz=%b ov=%b tag=%h, expected q=%h r=%h dz=%b ov=%b tag=%h",
                 sel, i, got.q, got.r, got.dz, got.ov, got.tag, exp.q, exp.r, exp.dz, exp.ov, exp.tag);
      end
      checks++;
      if (lat != elat) begin
        errors++; $display("FAIL directed_latency sel=%0d case=%0d: got %0d, expected %0d", sel, i, lat, elat);
      end
    end
  endtask

  task automatic test_backpressure();
    res_t first;
    res_t exp;
    int   n;
    int   spurious;
    @(negedge clk);
    drive_in(4, 1'b1, 1'b0, 32'd1000, 32'd3, 4'd9);
    @(posedge clk);
    @(negedge clk);
    drive_in(4, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    n = 1;
    while (!vld(4) && n < 100) begin
      @(negedge clk);
      n++;
    end
    exp = model(1'b0, 32'd1000, 32'd3, 4'd9);
    first = get_res(4);
    checks++;
    if (vld(4) !== 1'b1 || first !== exp) begin
      errors++; $display("FAIL bp_result: got valid=%b res=%h, expected valid=1 res=%h", vld(4), first, exp);
    end
    for (int k = 0; k < 10; k++) begin
      drive_in(4, 1'b1, 1'b1, $urandom, $urandom, 4'hA);
      @(negedge clk);
      checks++;
      if (get_res(4) !== first || vld(4) !== 1'b1 || rdy(4) !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d: got res=%h valid=%b ready=%b, expected res=%h valid=1 ready=0",
                 k, get_res(4), vld(4), rdy(4), first);
      end
    end
    drive_in(4, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive_ordy(4, 1'b1);
    @(negedge clk);
    drive_ordy(4, 1'b0);
    checks++;
    if (vld(4) !== 1'b0 || rdy(4) !== 1'b1) begin
      errors++; $display("FAIL bp_release: got valid=%b ready=%b, expected valid=0 ready=1", vld(4), rdy(4));
    end
    spurious = 0;
    repeat (15) begin
      @(negedge clk);
      if (vld(4) || !rdy(4)) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++; $display("FAIL bp_ignored_request: got %0d busy cycles, expected 0", spurious);
    end
  endtask

  task automatic test_ready_early();
    res_t got;
    res_t exp;
    int   hi;
    got = '0;
    hi  = 0;
    @(negedge clk);
    drive_ordy(4, 1'b1);
    drive_in(4, 1'b1, 1'b1, 32'hFFFF_FFCE, 32'd5, 4'd2);
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) drive_in(4, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      if (vld(4)) begin
        hi++;
        got = get_res(4);
      end
    end
    drive_ordy(4, 1'b0);
    exp = model(1'b1, 32'hFFFF_FFCE, 32'd5, 4'd2);
    checks++;
    if (hi != 1) begin
      errors++; $display("FAIL early_ready_pulse: got %0d valid cycles, expected 1", hi);
    end
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL early_ready_result: got %h, expected %h", got, exp);
    end
  endtask

  task automatic test_reset_abort();
    res_t got;
    res_t exp;
    res_t zero;
    int   lat;
    int   hi;
    zero = '0;
    @(negedge clk);
    drive_in(1, 1'b1, 1'b0, 32'd1234567, 32'd89, 4'd3);
    @(posedge clk);
    @(negedge clk);
    drive_in(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (vld(1) !== 1'b0 || rdy(1) !== 1'b1 || get_res(1) !== zero) begin
      errors++; $display("FAIL abort_reset_state: got valid=%b ready=%b res=%h, expected 0/1/0", vld(1), rdy(1), get_res(1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (vld(1) || !rdy(1)) hi++;
    end
    checks++;
    if (hi != 0) begin
      errors++; $display("FAIL abort_no_result: got %0d busy cycles, expected 0", hi);
    end
    run_req(1, 1'b1, 32'hFFFE_0000, 32'd77, 4'd6, got, lat);
    exp = model(1'b1, 32'hFFFE_0000, 32'd77, 4'd6);
    checks++;
    if (got !== exp || lat != 34) begin
      errors++; $display("FAIL abort_next_request: got res=%h lat=%0d, expected res=%h lat=34", got, lat, exp);
    end
  endtask

  task automatic test_random(input int sel, input int count);
    res_t        got;
    res_t        exp;
    int          lat;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  t;
    for (int i = 0; i < count; i++) begin
      s = 1'($urandom);
      a = $urandom;
      b = $urandom;
      t = 4'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15)) ^ ({32{1'($urandom)}});
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_req(sel, s, a, b, t, got, lat);
      exp = model(s, a, b, t);
      checks++;
      if (got !== exp || lat != exp_lat(sel, exp)) begin
        errors++;
        $display("FAIL random sel=%0d s=%b a=%h b=%h: got res=%h lat=%0d, expected res=%h lat=%0d",
                 sel, s, a, b, got, lat, exp, exp_lat(sel, exp));
      end
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_directed(1);
    test_directed(4);
    test_backpressure();
    test_ready_early();
    test_reset_abort();
    test_random(4, 2000);
    test_random(1, 300);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
